bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, 15, max cycles a granted transfer waits for mem_ack_i before abort (legal 1..255).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 i_req_i  input  1  instruction-fetch request (master 0), level, read-only.
REQ-005 i_addr_i  input  32  fetch address.
REQ-006 i_ready_o  output  1  one-cycle pulse: fetch transfer finished.
REQ-007 i_rdata_o  output  32  fetch read data, valid only while i_ready_o=1.
REQ-008 d_req_i  input  1  data request (master 1), level.
REQ-009 d_en_i  input  4  data byte-lane write enables; 4'b0000 = read.
REQ-010 d_addr_i  input  32  data address.
REQ-011 d_wdata_i  input  32  data write data.
REQ-012 d_ready_o  output  1  one-cycle pulse: data transfer finished.
REQ-013 d_rdata_o  output  32  data read data, valid only while d_ready_o=1.
REQ-014 err_o  output  1  pulses with i_ready_o or d_ready_o when that transfer timed out.
REQ-015 mem_req_o / mem_en_o / mem_addr_o / mem_wdata_o  output  1/4/32/32  shared memory-port request, byte enables, address, write data.
REQ-016 mem_ack_i  input  1  memory completion strobe; mem_rdata_i  input  32  read data valid with mem_ack_i.

Function
REQ-017 States: IDLE, BUSY; exactly one transfer outstanding at any time.
REQ-018 IDLE: any req sampled high -> pick winner, register its addr/en/wdata into mem_* outputs, latch grant owner, go BUSY; mem_req_o high from next cycle.
REQ-019 BUSY: mem_req_o and all mem_* outputs held constant until mem_ack_i sampled high or timeout.
REQ-020 mem_ack_i sampled high in BUSY -> next cycle: owner's ready_o=1 for one cycle, owner's rdata_o = registered mem_rdata_i, mem_req_o=0, state IDLE, err_o=0.
REQ-021 Latency: req at edge N -> mem_req_o at N+1; ack at edge M -> ready at M+1; next grant sampled at M+1, issued at M+2 (one idle bubble between transfers).
REQ-022 Wait counter, 8 bits, cleared on entering BUSY, +1 per BUSY cycle without ack; reaching MAX_WAIT -> abort: mem_req_o=0, owner ready_o=1 and err_o=1 for one cycle, rdata_o=0, state IDLE.
REQ-023 Ack and timeout in same cycle -> ack wins, err_o=0.
REQ-024 mem_ack_i in IDLE ignored; no output change.
REQ-025 Requester deasserting req while owner in BUSY: transfer still completes and ready pulse still issued; non-owner req changes in BUSY have no effect.
REQ-026 Non-owner ready_o, and both rdata_o when ready_o=0, held at 0.
REQ-027 Fetch grant drives mem_en_o=4'b0000 and mem_wdata_o=0.

Reset
REQ-028 rst_i high at an edge -> state IDLE, counter 0, mem_req_o=0, mem_en_o=0, mem_addr_o=0, mem_wdata_o=0, both ready_o=0, both rdata_o=0, err_o=0, round-robin pointer = data-first.
REQ-029 Reset mid-BUSY aborts transfer with no ready/err pulse; late ack afterwards ignored per REQ-024.

Configuration
REQ-030 Macro ARB_RR_EN defined: round-robin; on simultaneous reqs in IDLE, grant the master not granted last; pointer updates on each grant.
REQ-031 ARB_RR_EN undefined: fixed priority, data (master 1) always wins over fetch; no pointer register.
REQ-032 Single requester: granted immediately in both modes.

Verification
REQ-033 Fetch only, addr 0x100, ack 2 cycles after mem_req_o, rdata 0x00000013 -> i_ready_o one pulse with i_rdata_o=0x00000013, err_o=0.
REQ-034 Data write, en 4'b0011, addr 0x2000, wdata 0xDEADBEEF -> mem_en_o=4'b0011, mem_addr_o=0x2000, mem_wdata_o=0xDEADBEEF held until ack; d_ready_o one pulse.
REQ-035 Both reqs held high 4 transfers, ack 1 cycle each -> with ARB_RR_EN grants D,I,D,I; without, D,D,D,D while d_req_i high.
REQ-036 MAX_WAIT=3, data read, no ack -> mem_req_o drops after 3 BUSY cycles, d_ready_o=1, err_o=1, d_rdata_o=0.
REQ-037 rst_i asserted 1 cycle into BUSY, ack 1 cycle later -> mem_req_o=0 after reset edge, no ready/err pulse, state IDLE.
REQ-038 Ack coincident with timeout cycle (MAX_WAIT=2, ack on 2nd BUSY cycle) -> ready pulse with err_o=0 and rdata from mem_rdata_i.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master (fetch / data) arbiter onto one memory port, one transfer outstanding, with a wait timeout.
// Define ARB_RR_EN for round-robin arbitration; by default the data master has fixed priority.
module bus_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ready_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic [3:0]  d_en_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ready_o,
    output logic [31:0] d_rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic [3:0]  mem_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic       owner;          // 1 = data master holds the port
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       grant, grant_data, done_ack, done_abort;
`ifdef ARB_RR_EN
    logic       prefer_data;
`endif

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        done_ack   = 1'b0;
        done_abort = 1'b0;
        wait_inc   = wait_cnt + 8'd1;
        case (state)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    grant = 1'b1;
`ifdef ARB_RR_EN
                    grant_data = d_req_i && (!i_req_i || prefer_data);
`else
                    grant_data = d_req_i;
`endif
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // An ack in the timeout cycle still completes normally.
                if (mem_ack_i) begin
                    done_ack  = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_inc == WAIT_LIMIT) begin
                    done_abort = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner       <= 1'b0;
            wait_cnt    <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_en_o    <= 4'd0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            i_ready_o   <= 1'b0;
            d_ready_o   <= 1'b0;
            i_rdata_o   <= 32'd0;
            d_rdata_o   <= 32'd0;
            err_o       <= 1'b0;
`ifdef ARB_RR_EN
            prefer_data <= 1'b1;
`endif
        end else begin
            i_ready_o <= 1'b0;
            d_ready_o <= 1'b0;
            i_rdata_o <= 32'd0;
            d_rdata_o <= 32'd0;
            err_o     <= 1'b0;
            if (grant) begin
                owner       <= grant_data;
                wait_cnt    <= 8'd0;
                mem_req_o   <= 1'b1;
                mem_en_o    <= grant_data ? d_en_i : 4'd0;
                mem_addr_o  <= grant_data ? d_addr_i : i_addr_i;
                mem_wdata_o <= grant_data ? d_wdata_i : 32'd0;
`ifdef ARB_RR_EN
                prefer_data <= !grant_data;
`endif
            end
            if (state == BUSY) wait_cnt <= wait_inc;
            if (done_ack || done_abort) begin
                mem_req_o <= 1'b0;
                err_o     <= done_abort;
                if (owner) begin
                    d_ready_o <= 1'b1;
                    d_rdata_o <= done_ack ? mem_rdata_i : 32'd0;
                end else begin
                    i_ready_o <= 1'b1;
                    i_rdata_o <= done_ack ? mem_rdata_i : 32'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Three instances share the stimulus: default MAX_WAIT (modelled), MAX_WAIT=2 and MAX_WAIT=3.
module tb_bus_arbiter;
    localparam int MAXW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, i_req = 1'b0, d_req = 1'b0, mem_ack = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_en = '0;

    logic        i_ready, d_ready, err, mem_req;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_en;
    logic        i_ready2, d_ready2, err2, mem_req2;
    logic [31:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;
    logic [3:0]  mem_en2;
    logic        i_ready3, d_ready3, err3, mem_req3;
    logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic [3:0]  mem_en3;

    bus_arbiter dut (
        .clk_i(clk), .rst_i(rst), .i_req_i(i_req), .i_addr_i(i_addr),
        .i_ready_o(i_ready), .i_rdata_o(i_rdata), .d_req_i(d_req), .d_en_i(d_en),
        .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_ready_o(d_ready), .d_rdata_o(d_rdata),
        .err_o(err), .mem_req_o(mem_req), .mem_en_o(mem_en), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata));

    bus_arbiter #(.MAX_WAIT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .i_req_i(i_req), .i_addr_i(i_addr),
        .i_ready_o(i_ready2), .i_rdata_o(i_rdata2), .d_req_i(d_req), .d_en_i(d_en),
        .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_ready_o(d_ready2), .d_rdata_o(d_rdata2),
        .err_o(err2), .mem_req_o(mem_req2), .mem_en_o(mem_en2), .mem_addr_o(mem_addr2),
        .mem_wdata_o(mem_wdata2), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata));

    bus_arbiter #(.MAX_WAIT(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .i_req_i(i_req), .i_addr_i(i_addr),
        .i_ready_o(i_ready3), .i_rdata_o(i_rdata3), .d_req_i(d_req), .d_en_i(d_en),
        .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_ready_o(d_ready3), .d_rdata_o(d_rdata3),
        .err_o(err3), .mem_req_o(mem_req3), .mem_en_o(mem_en3), .mem_addr_o(mem_addr3),
        .mem_wdata_o(mem_wdata3), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one transfer in flight, counted in whole cycles.
    bit          model_ok = 0;
    bit          busy, own_data, last_data, pick_d;
    int          elapsed;
    logic        e_req, e_irdy, e_drdy, e_err;
    logic [3:0]  e_en;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

    always @(posedge clk) begin
        e_irdy = 0; e_drdy = 0; e_err = 0; e_irdata = 0; e_drdata = 0;
        if (rst) begin
            model_ok = 1; busy = 0; elapsed = 0; last_data = 0; own_data = 0;
            e_req = 0; e_en = 0; e_addr = 0; e_wdata = 0;
        end else if (!busy) begin
            if (i_req || d_req) begin
`ifdef ARB_RR_EN
                pick_d = d_req && (!i_req || !last_data);
`else
                pick_d = d_req;
`endif
                own_data = pick_d; last_data = pick_d; busy = 1; elapsed = 0;
                e_req = 1;
                e_en = pick_d ? d_en : 4'd0;
                e_addr = pick_d ? d_addr : i_addr;
                e_wdata = pick_d ? d_wdata : 32'd0;
            end
        end else begin
            elapsed++;
            if (mem_ack || elapsed == MAXW) begin
                busy = 0; e_req = 0; e_err = !mem_ack;
                if (own_data) begin e_drdy = 1; e_drdata = mem_ack ? mem_rdata : 32'd0; end
                else          begin e_irdy = 1; e_irdata = mem_ack ? mem_rdata : 32'd0; end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("i_ready", 32'(i_ready), 32'(e_irdy));
            chk("d_ready", 32'(d_ready), 32'(e_drdy));
            chk("i_rdata", i_rdata, e_irdata);
            chk("d_rdata", d_rdata, e_drdata);
            chk("err", 32'(err), 32'(e_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic exp_d [4];
        int   n;
        tick(); tick(); rst = 0;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Fetch read, ack two cycles after the request appears.
        i_req = 1; i_addr = 32'h100; tick(); i_req = 0;
        chk("f_req", 32'(mem_req), 32'd1);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_en", 32'(mem_en), 32'd0);
        tick(); tick();
        mem_ack = 1; mem_rdata = 32'h13; tick(); mem_ack = 0;
        chk("f_ready", 32'(i_ready), 32'd1);
        chk("f_rdata", i_rdata, 32'h13);
        chk("f_err", 32'(err), 32'd0);
        tick();
        chk("f_ready_pulse", 32'(i_ready), 32'd0);

        // Data write held while the requester's inputs move.
        d_req = 1; d_en = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; tick();
        d_req = 0; d_addr = 32'h9999; d_wdata = 32'h1; d_en = 4'hF; tick();
        chk("w_en", 32'(mem_en), 32'h3);
        chk("w_addr", mem_addr, 32'h2000);
        chk("w_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1; tick(); mem_ack = 0;
        chk("w_ready", 32'(d_ready), 32'd1);
        chk("w_iready", 32'(i_ready), 32'd0);

        // Both masters requesting: grant order.
        do_reset();
        d_en = 0; i_addr = 32'h40; d_addr = 32'h80; i_req = 1; d_req = 1;
`ifdef ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (mem_req !== 1'b1 && n < 10) begin tick(); n++; end
            if (n >= 10) chk("grant_wait", 32'd0, 32'd1);
            chk("grant_order", 32'(mem_addr == 32'h80), 32'(exp_d[t]));
            mem_ack = 1; tick(); mem_ack = 0;
        end
        i_req = 0; d_req = 0;
        tick();

        // Data read with no ack: each instance aborts at its own limit.
        do_reset();
        d_req = 1; d_en = 0; d_addr = 32'h300; mem_rdata = 32'hFFFFFFFF; tick(); d_req = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 3) chk("to3_req_held", 32'(mem_req3), 32'd1);
            if (k == 3) begin
                chk("to2_ready", 32'(d_ready2), 32'd1);
                chk("to2_err", 32'(err2), 32'd1);
                chk("to2_req", 32'(mem_req2), 32'd0);
            end
            if (k == 4) begin
                chk("to3_req", 32'(mem_req3), 32'd0);
                chk("to3_ready", 32'(d_ready3), 32'd1);
                chk("to3_err", 32'(err3), 32'd1);
                chk("to3_rdata", d_rdata3, 32'd0);
            end
            if (k == 16) begin
                chk("to15_ready", 32'(d_ready), 32'd1);
                chk("to15_err", 32'(err), 32'd1);
            end
            tick();
        end

        // Ack arriving in the same cycle as the MAX_WAIT=2 timeout.
        d_req = 1; d_addr = 32'h400; mem_rdata = 32'hCAFE0001; tick(); d_req = 0;
        tick();
        mem_ack = 1; tick(); mem_ack = 0;
        chk("co2_ready", 32'(d_ready2), 32'd1);
        chk("co2_err", 32'(err2), 32'd0);
        chk("co2_rdata", d_rdata2, 32'hCAFE0001);
        tick();

        // Ack while idle is ignored.
        mem_ack = 1; mem_rdata = 32'h55; tick(); mem_ack = 0;
        chk("idle_ack_i", 32'(i_ready), 32'd0);
        chk("idle_ack_d", 32'(d_ready), 32'd0);

        // Reset one cycle into a transfer, then a late ack.
        i_req = 1; i_addr = 32'h500; tick(); i_req = 0;
        rst = 1; tick(); rst = 0;
        chk("mr_req", 32'(mem_req), 32'd0);
        chk("mr_iready", 32'(i_ready), 32'd0);
        mem_ack = 1; tick(); mem_ack = 0;
        chk("mr_late_iready", 32'(i_ready), 32'd0);
        chk("mr_late_err", 32'(err), 32'd0);
        chk("mr_late_req", 32'(mem_req), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
